// File: rtl/divider_pkg.sv
// Shared definitions for the divider family: default measurement ranges and the
// ratio-meter FSM state encoding, reused by divider benches.
package divider_pkg;
   localparam int DEF_MAX_COUNT  = 255;
   localparam int DEF_LOCK_COUNT = 4;

   typedef enum logic [1:0] {
      ACQ    = 2'd0,
      MEAS   = 2'd1,
      LOCKED = 2'd2
   } meter_state_t;
endpackage

// File: rtl/divider_ratio_meter_edge_sync.sv
// Brings sig_in into the clk_in domain and flags every transition of the
// synchronized level, both polarities.
module edge_sync
   import divider_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_in,
   input  logic rst,
   input  logic sig_in,
   output logic s,
   output logic sig_edge
);

   logic s_prev;

   generate
      if (SYNC_STAGES == 0) begin : g_direct
         assign s = sig_in;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] chain;
         always_ff @(posedge clk_in) begin
            if (rst) begin
               chain <= '0;
            end else begin
               chain[0] <= sig_in;
               for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
            end
         end
         assign s = chain[SYNC_STAGES-1];
      end
   endgenerate

   always_ff @(posedge clk_in) begin
      if (rst) s_prev <= 1'b0;
      else     s_prev <= s;
   end

   assign sig_edge = s ^ s_prev;

endmodule

// File: rtl/divider_ratio_meter.sv
// Measures the half-period of a divided clock/strobe in clk_in cycles, reports
// each result, detects a stable ratio (locked) and a non-toggling input (stuck).
module divider_ratio_meter
   import divider_pkg::*;
#(
   parameter int  SYNC_STAGES = 2,
   parameter int  MAX_COUNT   = DEF_MAX_COUNT,
   parameter int  LOCK_COUNT  = DEF_LOCK_COUNT,
   localparam int CNT_W       = $clog2(MAX_COUNT + 1)
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             sig_in,
   output logic [CNT_W-1:0] half_period,
   output logic             meas_valid,
   output logic             ratio_change,
   output logic             locked,
   output logic             stuck,
   output meter_state_t     fsm_state
);

   localparam int               MATCH_W = $clog2(LOCK_COUNT + 1);
   localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_COUNT);
   localparam logic [CNT_W-1:0] MAX_M1  = CNT_W'(MAX_COUNT - 1);
   localparam logic [MATCH_W-1:0] LOCK_M = MATCH_W'(LOCK_COUNT);

   logic               s;
   logic               sig_edge;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   m;
   logic               timeout;
   logic [MATCH_W-1:0] match, match_n, match_inc;
   meter_state_t       state, state_n;
   logic [CNT_W-1:0]   half_period_n;
   logic               meas_valid_n, ratio_change_n, locked_n, stuck_n;

   edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
      .clk_in   (clk_in),
      .rst      (rst),
      .sig_in   (sig_in),
      .s        (s),
      .sig_edge (sig_edge)
   );

   // Cycles since the last edge, minus one; saturates so a dead input never wraps.
   always_ff @(posedge clk_in) begin
      if (rst)                cnt <= '0;
      else if (sig_edge)      cnt <= '0;
      else if (cnt != MAX_C)  cnt <= cnt + CNT_W'(1);
   end

   assign m         = (cnt == MAX_C) ? MAX_C : cnt + CNT_W'(1);
   assign timeout   = !sig_edge && (cnt == MAX_M1);
   assign match_inc = (match == LOCK_M) ? LOCK_M : match + MATCH_W'(1);

   // meas_valid is a one-cycle strobe with no back-pressure: half_period must be
   // taken in the cycle it is high; ratio_change only ever pulses alongside it.
   always_comb begin
      state_n        = state;
      half_period_n  = half_period;
      meas_valid_n   = 1'b0;
      ratio_change_n = 1'b0;
      locked_n       = locked;
      stuck_n        = stuck;
      match_n        = match;
      unique case (state)
         ACQ: begin
            // The acquiring edge only opens the first interval; it is not measured.
            if (sig_edge) begin
               state_n = MEAS;
               stuck_n = 1'b0;
            end else if (timeout) begin
               stuck_n = 1'b1;
            end
         end
         MEAS: begin
            if (sig_edge) begin
               meas_valid_n  = 1'b1;
               half_period_n = m;
               if (match == '0) begin
                  match_n = MATCH_W'(1);
               end else if (m == half_period) begin
                  match_n = match_inc;
               end else begin
                  match_n        = MATCH_W'(1);
                  ratio_change_n = 1'b1;
               end
               if (match_n >= LOCK_M) begin
                  locked_n = 1'b1;
                  state_n  = LOCKED;
               end
            end else if (timeout) begin
               stuck_n  = 1'b1;
               locked_n = 1'b0;
               match_n  = '0;
               state_n  = ACQ;
            end
         end
         LOCKED: begin
            if (sig_edge) begin
               meas_valid_n  = 1'b1;
               half_period_n = m;
               if (m != half_period) begin
                  locked_n       = 1'b0;
                  match_n        = MATCH_W'(1);
                  ratio_change_n = 1'b1;
                  state_n        = MEAS;
               end
            end else if (timeout) begin
               stuck_n  = 1'b1;
               locked_n = 1'b0;
               match_n  = '0;
               state_n  = ACQ;
            end
         end
         default: state_n = ACQ;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state        <= ACQ;
         half_period  <= '0;
         meas_valid   <= 1'b0;
         ratio_change <= 1'b0;
         locked       <= 1'b0;
         stuck        <= 1'b0;
         match        <= '0;
      end else begin
         state        <= state_n;
         half_period  <= half_period_n;
         meas_valid   <= meas_valid_n;
         ratio_change <= ratio_change_n;
         locked       <= locked_n;
         stuck        <= stuck_n;
         match        <= match_n;
      end
   end

   assign fsm_state = state;

endmodule

// File: tb/tb_divider_ratio_meter.sv
// Bench for divider_ratio_meter: two instances (2-stage sync and direct) share
// one stimulus and are checked every cycle against an interval-based model.
module tb_divider_ratio_meter;
   import divider_pkg::*;

   localparam int MAXC  = 255;
   localparam int LOCKC = 4;
   localparam int W     = 8;

   logic clk_in = 1'b0;
   logic rst    = 1'b1;
   logic sig_in = 1'b0;
   logic cur    = 1'b0;

   logic [W-1:0] hp_a, hp_b;
   logic         mv_a, mv_b, rc_a, rc_b, lk_a, lk_b, st_a, st_b;
   meter_state_t fs_a, fs_b;

   always #5 clk_in = ~clk_in;

   divider_ratio_meter #(.SYNC_STAGES(2), .MAX_COUNT(MAXC), .LOCK_COUNT(LOCKC)) dut_a (
      .clk_in(clk_in), .rst(rst), .sig_in(sig_in), .half_period(hp_a), .meas_valid(mv_a),
      .ratio_change(rc_a), .locked(lk_a), .stuck(st_a), .fsm_state(fs_a)
   );

   divider_ratio_meter #(.SYNC_STAGES(0), .MAX_COUNT(MAXC), .LOCK_COUNT(LOCKC)) dut_b (
      .clk_in(clk_in), .rst(rst), .sig_in(sig_in), .half_period(hp_b), .meas_valid(mv_b),
      .ratio_change(rc_b), .locked(lk_b), .stuck(st_b), .fsm_state(fs_b)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: sampled-input history plus, per instance, the time of the
   // last edge and the list of measurements since the input was (re)acquired.
   int   cyc = 0;
   logic hist [0:3];
   int   last_edge [2];
   bit   acq [2];
   bit   m_stuck [2];
   bit   m_locked [2];
   int   run [2];
   int   nmeas [2];
   int   m_hp [2];
   bit   e_mv [2];
   bit   e_rc [2];
   logic [W-1:0] exp_qa[$];
   logic [W-1:0] exp_qb[$];

   int n_mv_a, n_rc_a, n_stuck_a, n_mv_b;

   task automatic model_reset();
      for (int i = 0; i < 4; i++) hist[i] = 1'b0;
      for (int d = 0; d < 2; d++) begin
         last_edge[d] = cyc;
         acq[d] = 0; m_stuck[d] = 0; m_locked[d] = 0;
         run[d] = 0; nmeas[d] = 0; m_hp[d] = 0; e_mv[d] = 0; e_rc[d] = 0;
      end
      exp_qa.delete();
      exp_qb.delete();
   endtask

   task automatic model_step();
      int sd, interval;
      bit e;
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = sig_in;
      for (int d = 0; d < 2; d++) begin
         sd = (d == 0) ? 2 : 0;
         e = (hist[sd] != hist[sd+1]);
         interval = cyc - last_edge[d];
         e_mv[d] = 0;
         e_rc[d] = 0;
         if (e) begin
            if (!acq[d]) begin
               acq[d] = 1; m_stuck[d] = 0; nmeas[d] = 0; run[d] = 0;
            end else begin
               e_mv[d] = 1;
               if (nmeas[d] == 0) run[d] = 1;
               else if (interval == m_hp[d]) run[d]++;
               else begin run[d] = 1; e_rc[d] = 1; end
               m_hp[d] = interval;
               nmeas[d]++;
               m_locked[d] = (run[d] >= LOCKC);
               if (d == 0) exp_qa.push_back(W'(interval));
               else        exp_qb.push_back(W'(interval));
            end
            last_edge[d] = cyc;
         end else if (interval == MAXC) begin
            m_stuck[d] = 1; m_locked[d] = 0; acq[d] = 0; nmeas[d] = 0; run[d] = 0;
         end
      end
   endtask

   // One clock: drive at negedge, advance the model at posedge, compare after it.
   task automatic tick(input logic v, input logic r);
      logic [W-1:0] a_hp, x_hp, q_hp;
      logic a_mv, a_rc, a_lk, a_st;
      meter_state_t a_fs, x_fs;
      @(negedge clk_in);
      sig_in = v;
      rst    = r;
      @(posedge clk_in);
      cyc++;
      if (r) model_reset();
      else   model_step();
      #1;
      for (int d = 0; d < 2; d++) begin
         if (d == 0) begin a_hp = hp_a; a_mv = mv_a; a_rc = rc_a; a_lk = lk_a; a_st = st_a; a_fs = fs_a; end
         else        begin a_hp = hp_b; a_mv = mv_b; a_rc = rc_b; a_lk = lk_b; a_st = st_b; a_fs = fs_b; end
         x_hp = W'(m_hp[d]);
         x_fs = !acq[d] ? ACQ : (m_locked[d] ? LOCKED : MEAS);
         checks += 6;
         if (a_hp !== x_hp) begin failures++; $display("FAIL half_period dut%0d cyc=%0d got=%0d exp=%0d", d, cyc, a_hp, x_hp); end
         if (a_mv !== e_mv[d]) begin failures++; $display("FAIL meas_valid dut%0d cyc=%0d got=%b exp=%b", d, cyc, a_mv, e_mv[d]); end
         if (a_rc !== e_rc[d]) begin failures++; $display("FAIL ratio_change dut%0d cyc=%0d got=%b exp=%b", d, cyc, a_rc, e_rc[d]); end
         if (a_lk !== m_locked[d]) begin failures++; $display("FAIL locked dut%0d cyc=%0d got=%b exp=%b", d, cyc, a_lk, m_locked[d]); end
         if (a_st !== m_stuck[d]) begin failures++; $display("FAIL stuck dut%0d cyc=%0d got=%b exp=%b", d, cyc, a_st, m_stuck[d]); end
         if (a_fs !== x_fs) begin failures++; $display("FAIL fsm_state dut%0d cyc=%0d got=%0d exp=%0d", d, cyc, a_fs, x_fs); end
         if (a_mv === 1'b1) begin
            checks++;
            if (d == 0 && exp_qa.size() > 0) q_hp = exp_qa.pop_front();
            else if (d == 1 && exp_qb.size() > 0) q_hp = exp_qb.pop_front();
            else q_hp = 'x;
            if (a_hp !== q_hp) begin failures++; $display("FAIL scoreboard dut%0d cyc=%0d got=%0d exp=%0d", d, cyc, a_hp, q_hp); end
         end
      end
      n_mv_a    += int'(mv_a);
      n_rc_a    += int'(rc_a);
      n_stuck_a += int'(st_a);
      n_mv_b    += int'(mv_b);
   endtask

   task automatic toggle(input int k, input int n);
      for (int i = 0; i < n; i++) begin
         cur = ~cur;
         repeat (k) tick(cur, 1'b0);
      end
   endtask

   task automatic clear_counts();
      n_mv_a = 0; n_rc_a = 0; n_stuck_a = 0; n_mv_b = 0;
   endtask

   task automatic test_reset();
      cur = 1'b0;
      repeat (3) tick(cur, 1'b1);
      tick(cur, 1'b0);
      checks += 3;
      if (hp_a !== '0 || mv_a !== 1'b0 || rc_a !== 1'b0) begin failures++; $display("FAIL reset_outs_a got=%0d/%b/%b exp=0/0/0", hp_a, mv_a, rc_a); end
      if (lk_a !== 1'b0 || st_a !== 1'b0) begin failures++; $display("FAIL reset_flags_a got=%b/%b exp=0/0", lk_a, st_a); end
      if (fs_b !== ACQ) begin failures++; $display("FAIL reset_state_b got=%0d exp=%0d", fs_b, ACQ); end
   endtask

   task automatic test_div3();
      clear_counts();
      toggle(3, 8);
      checks += 3;
      if (hp_a !== W'(3)) begin failures++; $display("FAIL div3_hp got=%0d exp=3", hp_a); end
      if (lk_a !== 1'b1) begin failures++; $display("FAIL div3_locked got=%b exp=1", lk_a); end
      if (n_mv_a != 7) begin failures++; $display("FAIL div3_pulses got=%0d exp=7", n_mv_a); end
   endtask

   task automatic test_switch5();
      clear_counts();
      toggle(5, 6);
      checks += 3;
      if (n_rc_a != 1) begin failures++; $display("FAIL switch5_rc got=%0d exp=1", n_rc_a); end
      if (hp_a !== W'(5)) begin failures++; $display("FAIL switch5_hp got=%0d exp=5", hp_a); end
      if (lk_a !== 1'b1) begin failures++; $display("FAIL switch5_relock got=%b exp=1", lk_a); end
   endtask

   task automatic test_stuck();
      clear_counts();
      repeat (300) tick(cur, 1'b0);
      checks += 3;
      if (st_a !== 1'b1) begin failures++; $display("FAIL stuck_set got=%b exp=1", st_a); end
      if (lk_a !== 1'b0) begin failures++; $display("FAIL stuck_unlock got=%b exp=0", lk_a); end
      if (n_mv_a != 0) begin failures++; $display("FAIL stuck_no_meas got=%0d exp=0", n_mv_a); end
   endtask

   task automatic test_fast();
      toggle(1, 10);
      checks += 3;
      if (hp_b !== W'(1) || lk_b !== 1'b1) begin failures++; $display("FAIL fast_b got=%0d/%b exp=1/1", hp_b, lk_b); end
      if (hp_a !== W'(1)) begin failures++; $display("FAIL fast_a_hp got=%0d exp=1", hp_a); end
      if (st_a !== 1'b0) begin failures++; $display("FAIL fast_stuck_clear got=%b exp=0", st_a); end
   endtask

   task automatic test_slow();
      clear_counts();
      toggle(255, 6);
      checks += 3;
      if (hp_a !== W'(255)) begin failures++; $display("FAIL slow_hp got=%0d exp=255", hp_a); end
      if (lk_a !== 1'b1) begin failures++; $display("FAIL slow_locked got=%b exp=1", lk_a); end
      if (n_stuck_a != 0) begin failures++; $display("FAIL slow_never_stuck got=%0d exp=0", n_stuck_a); end
   endtask

   task automatic test_reset_mid();
      toggle(4, 7);
      repeat (2) tick(cur, 1'b0);
      tick(cur, 1'b1);
      checks += 2;
      if (hp_a !== '0 || lk_a !== 1'b0 || mv_a !== 1'b0 || st_a !== 1'b0) begin failures++; $display("FAIL rstmid_outs got=%0d/%b/%b/%b exp=0/0/0/0", hp_a, lk_a, mv_a, st_a); end
      if (fs_a !== ACQ) begin failures++; $display("FAIL rstmid_state got=%0d exp=%0d", fs_a, ACQ); end
      clear_counts();
      cur = 1'b1;
      repeat (4) tick(cur, 1'b0);
      checks += 2;
      if (n_mv_a != 0 || n_mv_b != 0) begin failures++; $display("FAIL rstmid_first_edge got=%0d/%0d exp=0/0", n_mv_a, n_mv_b); end
      if (fs_a !== MEAS) begin failures++; $display("FAIL rstmid_acquired got=%0d exp=%0d", fs_a, MEAS); end
   endtask

   task automatic test_sweep();
      for (int div = 1; div <= 8; div++) begin
         toggle(div, 8);
         checks += 2;
         if (hp_a !== W'(div) || lk_a !== 1'b1) begin failures++; $display("FAIL sweep_a div=%0d got=%0d/%b exp=%0d/1", div, hp_a, lk_a, div); end
         if (hp_b !== W'(div) || lk_b !== 1'b1) begin failures++; $display("FAIL sweep_b div=%0d got=%0d/%b exp=%0d/1", div, hp_b, lk_b, div); end
      end
   endtask

   task automatic test_random();
      int r;
      for (int seg = 0; seg < 30; seg++) begin
         r = $urandom_range(0, 9);
         if (r == 0)      tick(cur, 1'b1);
         else if (r == 1) repeat ($urandom_range(240, 270)) tick(cur, 1'b0);
         else             toggle($urandom_range(1, 12), $urandom_range(2, 10));
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_div3();
      test_switch5();
      test_stuck();
      test_fast();
      test_slow();
      test_reset_mid();
      test_sweep();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
